// File: rtl/rti_write_arbiter.sv
// rti_write_arbiter: shares the RTI_Core FIFO write port between NUM_CH edge-counter channels.
//   clk, reset      : system clock, synchronous active-high reset
//   flush           : synchronous clear of pending entries, drop state and write strobe
//   ch_write/ch_data: per-channel one-cycle write pulse and packed payloads
//   fifo_full       : RTI FIFO full flag
//   fifo_write/din  : registered write strobe and {channel ID, payload}
//   pending         : per-channel holding register occupied
//   overflow        : sticky per-channel drop flag
//   drop_count      : saturating total of dropped words
module rti_write_arbiter #(
  parameter int NUM_CH = 4,
  parameter int CH_WIDTH = 120,
  parameter int ID_WIDTH = 8,
  parameter int DROP_CNT_WIDTH = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         flush,
  input  logic [NUM_CH-1:0]            ch_write,
  input  logic [NUM_CH*CH_WIDTH-1:0]   ch_data,
  input  logic                         fifo_full,
  output logic                         fifo_write,
  output logic [ID_WIDTH+CH_WIDTH-1:0] fifo_din,
  output logic [NUM_CH-1:0]            pending,
  output logic [NUM_CH-1:0]            overflow,
  output logic [DROP_CNT_WIDTH-1:0]    drop_count
);
  localparam int PTR_W = $clog2(NUM_CH);
  localparam int CW = DROP_CNT_WIDTH + 9;
  logic [CH_WIDTH-1:0] hold [NUM_CH];
  logic [PTR_W-1:0] rr_ptr, gnt_idx;
  logic gnt_any, gnt;
  logic [NUM_CH-1:0] gnt_vec, cap, drop;
  logic [CW-1:0] drop_sum;
  logic [DROP_CNT_WIDTH-1:0] drop_next;
  function automatic logic [PTR_W-1:0] wrap(input int s);
    return PTR_W'(s >= NUM_CH ? s - NUM_CH : s);
  endfunction
  // Scan from farthest to nearest so the channel closest after rr_ptr is the last (winning) assignment.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    for (int k = NUM_CH; k >= 1; k--)
      if (pending[wrap(int'(rr_ptr) + k)]) begin
        gnt_any = 1'b1;
        gnt_idx = wrap(int'(rr_ptr) + k);
      end
  end
  // Blocking on fifo_write keeps writes one apart so the registered strobe tolerates a one-cycle-stale full flag.
  assign gnt = gnt_any && !fifo_full && !fifo_write;
  assign gnt_vec = gnt ? NUM_CH'(1) << gnt_idx : '0;
  assign cap = ch_write & (~pending | gnt_vec);
  assign drop = ch_write & pending & ~gnt_vec;
  always_comb begin
    drop_sum = CW'(drop_count);
    for (int i = 0; i < NUM_CH; i++) drop_sum = drop_sum + CW'(drop[i]);
  end
  assign drop_next = drop_sum > CW'({DROP_CNT_WIDTH{1'b1}}) ? {DROP_CNT_WIDTH{1'b1}} : drop_sum[DROP_CNT_WIDTH-1:0];
  always_ff @(posedge clk)
    for (int i = 0; i < NUM_CH; i++)
      if (!reset && !flush && cap[i]) hold[i] <= ch_data[i*CH_WIDTH +: CH_WIDTH];
  always_ff @(posedge clk) begin
    if (reset) begin
      fifo_write <= 1'b0;
      fifo_din <= '0;
      pending <= '0;
      overflow <= '0;
      drop_count <= '0;
      rr_ptr <= PTR_W'(NUM_CH - 1);
    end else if (flush) begin
      fifo_write <= 1'b0;
      fifo_din <= '0;
      pending <= '0;
      overflow <= '0;
      drop_count <= '0;
    end else begin
      fifo_write <= gnt;
      if (gnt) begin
        fifo_din <= {ID_WIDTH'(gnt_idx), hold[gnt_idx]};
        rr_ptr <= gnt_idx;
      end
      pending <= (pending & ~gnt_vec) | cap;
      overflow <= overflow | drop;
      drop_count <= drop_next;
    end
  end
endmodule
